ddr_lane_adapter: RTL and testbench

DDR_LANE_ADAPTER -- requirements
Module: ddr_lane_adapter

---
 rtl/ddr_lane_adapter.sv | 174 +++++++++++++++++
 tb/tb_ddr_lane_adapter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_lane_adapter.sv
// ddr_lane_adapter: bridges a narrow 64-bit AXI slave port onto a 512-bit DDR AXI master port
module ddr_lane_adapter #(
  parameter int ID_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_aw_valid,
  input  logic [31:0]     s_aw_addr,
  input  logic [7:0]      s_aw_len,
  input  logic [2:0]      s_aw_size,
  input  logic [ID_W-1:0] s_aw_id,
  output logic            s_aw_ready,
  input  logic            s_w_valid,
  input  logic [63:0]     s_w_data,
  input  logic [7:0]      s_w_strb,
  input  logic            s_w_last,
  output logic            s_w_ready,
  output logic            s_b_valid,
  output logic [1:0]      s_b_resp,
  output logic [ID_W-1:0] s_b_id,
  input  logic            s_b_ready,
  input  logic            s_ar_valid,
  input  logic [31:0]     s_ar_addr,
  input  logic [7:0]      s_ar_len,
  input  logic [2:0]      s_ar_size,
  input  logic [ID_W-1:0] s_ar_id,
  output logic            s_ar_ready,
  output logic            s_r_valid,
  output logic [63:0]     s_r_data,
  output logic [1:0]      s_r_resp,
  output logic            s_r_last,
  output logic [ID_W-1:0] s_r_id,
  input  logic            s_r_ready,
  output logic            m_aw_valid,
  output logic [63:0]     m_aw_addr,
  output logic [7:0]      m_aw_len,
  output logic [2:0]      m_aw_size,
  output logic [ID_W-1:0] m_aw_id,
  input  logic            m_aw_ready,
  output logic            m_w_valid,
  output logic [511:0]    m_w_data,
  output logic [63:0]     m_w_strb,
  output logic            m_w_last,
  input  logic            m_w_ready,
  input  logic            m_b_valid,
  input  logic [1:0]      m_b_resp,
  input  logic [ID_W-1:0] m_b_id,
  output logic            m_b_ready,
  output logic            m_ar_valid,
  output logic [63:0]     m_ar_addr,
  output logic [7:0]      m_ar_len,
  output logic [2:0]      m_ar_size,
  output logic [ID_W-1:0] m_ar_id,
  input  logic            m_ar_ready,
  input  logic            m_r_valid,
  input  logic [511:0]    m_r_data,
  input  logic [1:0]      m_r_resp,
  input  logic            m_r_last,
  input  logic [ID_W-1:0] m_r_id,
  output logic            m_r_ready
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] aw_addr, ar_addr, beat_addr_w, beat_addr_r;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_size_eff, ar_size_eff, lane_w, lane_r;
  logic [ID_W-1:0] aw_id, ar_id;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_aw_valid & s_aw_ready;
  assign w_hs = s_w_valid & s_w_ready;
  assign b_hs = m_b_valid & m_b_ready;
  assign ar_hs = s_ar_valid & s_ar_ready;
  assign r_hs = m_r_valid & m_r_ready;
  assign aw_size_eff = aw_size > 3'd3 ? 3'd3 : aw_size;
  assign ar_size_eff = ar_size > 3'd3 ? 3'd3 : ar_size;
  assign lane_w = beat_addr_w[5:3];
  assign lane_r = beat_addr_r[5:3];
  // write FSM state register
  always_ff @(posedge clock)
    w_state <= reset ? W_IDLE : w_next;
  // write FSM transitions: one outstanding write from AW through B
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_ADDR;
      W_ADDR:  if (m_aw_ready) w_next = W_DATA;
      W_DATA:  if (w_hs && s_w_last) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end
  // write channel outputs: W and B pass through only in their own states
  always_comb begin
    s_aw_ready = w_state == W_IDLE;
    m_aw_valid = w_state == W_ADDR;
    m_aw_addr = {32'b0, aw_addr};
    m_aw_len = aw_len;
    m_aw_size = aw_size_eff;
    m_aw_id = aw_id;
    s_w_ready = (w_state == W_DATA) & m_w_ready;
    m_w_valid = (w_state == W_DATA) & s_w_valid;
    m_w_last = (w_state == W_DATA) & s_w_last;
    m_w_data = {8{s_w_data}};
    m_w_strb = w_state == W_DATA ? {56'b0, s_w_strb} << {lane_w, 3'b0} : 64'b0;
    s_b_valid = (w_state == W_RESP) & m_b_valid;
    m_b_ready = (w_state == W_RESP) & s_b_ready;
    s_b_resp = m_b_resp;
    s_b_id = m_b_id;
  end
  // write address capture and per-beat lane address tracking
  always_ff @(posedge clock)
    if (reset) begin
      aw_addr <= '0;
      aw_len <= '0;
      aw_size <= '0;
      aw_id <= '0;
      beat_addr_w <= '0;
    end else if (aw_hs) begin
      aw_addr <= s_aw_addr;
      aw_len <= s_aw_len;
      aw_size <= s_aw_size;
      aw_id <= s_aw_id;
      beat_addr_w <= s_aw_addr;
    end else if (w_hs) begin
      beat_addr_w <= beat_addr_w + (32'd1 << aw_size_eff);
    end
  // read FSM state register
  always_ff @(posedge clock)
    r_state <= reset ? R_IDLE : r_next;
  // read FSM transitions: one outstanding read from AR through last R beat
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_ADDR;
      R_ADDR:  if (m_ar_ready) r_next = R_DATA;
      R_DATA:  if (r_hs && m_r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end
  // read channel outputs: R passes through with the active 64-bit lane selected
  always_comb begin
    s_ar_ready = r_state == R_IDLE;
    m_ar_valid = r_state == R_ADDR;
    m_ar_addr = {32'b0, ar_addr};
    m_ar_len = ar_len;
    m_ar_size = ar_size_eff;
    m_ar_id = ar_id;
    s_r_valid = (r_state == R_DATA) & m_r_valid;
    m_r_ready = (r_state == R_DATA) & s_r_ready;
    s_r_data = m_r_data[{lane_r, 6'b0} +: 64];
    s_r_last = (r_state == R_DATA) & m_r_last;
    s_r_resp = m_r_resp;
    s_r_id = m_r_id;
  end
  // read address capture and per-beat lane address tracking
  always_ff @(posedge clock)
    if (reset) begin
      ar_addr <= '0;
      ar_len <= '0;
      ar_size <= '0;
      ar_id <= '0;
      beat_addr_r <= '0;
    end else if (ar_hs) begin
      ar_addr <= s_ar_addr;
      ar_len <= s_ar_len;
      ar_size <= s_ar_size;
      ar_id <= s_ar_id;
      beat_addr_r <= s_ar_addr;
    end else if (r_hs) begin
      beat_addr_r <= beat_addr_r + (32'd1 << ar_size_eff);
    end
endmodule

// File: tb/tb_ddr_lane_adapter.sv
// tb_ddr_lane_adapter: directed and randomized checks of the narrow-to-wide AXI lane adapter
module tb_ddr_lane_adapter;
  localparam int ID_W = 16;
  logic clock = 0, reset;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_last, s_w_ready, s_b_valid, s_b_ready;
  logic [31:0] s_aw_addr, s_ar_addr;
  logic [7:0] s_aw_len, s_ar_len, s_w_strb;
  logic [2:0] s_aw_size, s_ar_size;
  logic [ID_W-1:0] s_aw_id, s_b_id, s_ar_id, s_r_id;
  logic [63:0] s_w_data, s_r_data;
  logic [1:0] s_b_resp, s_r_resp;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_last, s_r_ready;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_last, m_w_ready, m_b_valid, m_b_ready;
  logic [63:0] m_aw_addr, m_ar_addr, m_w_strb;
  logic [7:0] m_aw_len, m_ar_len;
  logic [2:0] m_aw_size, m_ar_size;
  logic [ID_W-1:0] m_aw_id, m_b_id, m_ar_id, m_r_id;
  logic [511:0] m_w_data, m_r_data;
  logic [1:0] m_b_resp, m_r_resp;
  logic m_ar_valid, m_ar_ready, m_r_valid, m_r_last, m_r_ready;
  int n_assert = 0, n_fail = 0;
  logic [31:0] w_addr, r_addr;
  logic [7:0] w_len, r_len;
  logic [2:0] w_size, r_size;
  logic [ID_W-1:0] w_id, r_id;
  logic [7:0] strb_q[$];

  ddr_lane_adapter #(.ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_id(s_aw_id), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_w_ready(s_w_ready),
    .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_id(s_b_id), .s_b_ready(s_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_id(s_ar_id), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_id(s_r_id), .s_r_ready(s_r_ready),
    .m_aw_valid(m_aw_valid), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_id(m_aw_id), .m_aw_ready(m_aw_ready),
    .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_w_ready(m_w_ready),
    .m_b_valid(m_b_valid), .m_b_resp(m_b_resp), .m_b_id(m_b_id), .m_b_ready(m_b_ready),
    .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_id(m_ar_id), .m_ar_ready(m_ar_ready),
    .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_id(m_r_id), .m_r_ready(m_r_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] eff(input logic [2:0] s);
    return s > 3'd3 ? 3'd3 : s;
  endfunction

  // lane of beat n: the byte address base + n * bytes-per-beat, taken modulo 2^32, selects 64-bit lane addr[5:3]
  function automatic logic [2:0] lane_of(input logic [31:0] base, input int n, input logic [2:0] s);
    logic [31:0] a;
    a = base + 32'(n) * (32'd1 << eff(s));
    return a[5:3];
  endfunction

  task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [ID_W-1:0] id);
    s_aw_addr = a; s_aw_len = l; s_aw_size = s; s_aw_id = id;
    w_addr = a; w_len = l; w_size = s; w_id = id;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [ID_W-1:0] id);
    s_ar_addr = a; s_ar_len = l; s_ar_size = s; s_ar_id = id;
    r_addr = a; r_len = l; r_size = s; r_id = id;
  endtask

  task automatic issue_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    set_aw(a, l, s, ID_W'($urandom));
    s_aw_valid = 1;
    #1 chk("s_aw_ready_idle", s_aw_ready, 1);
    tick;
    s_aw_valid = 0;
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    set_ar(a, l, s, ID_W'($urandom));
    s_ar_valid = 1;
    #1 chk("s_ar_ready_idle", s_ar_ready, 1);
    tick;
    s_ar_valid = 0;
  endtask

  task automatic aw_phase(input int stall);
    for (int c = 0; c <= stall; c++) begin
      m_aw_ready = (c == stall);
      m_w_ready = 1;
      #1;
      chk("m_aw_valid", m_aw_valid, 1);
      chk("m_aw_addr", m_aw_addr, {32'b0, w_addr});
      chk("m_aw_len", m_aw_len, w_len);
      chk("m_aw_size", m_aw_size, eff(w_size));
      chk("m_aw_id", m_aw_id, w_id);
      chk("s_w_ready_addr", s_w_ready, 0);
      chk("s_aw_ready_busy", s_aw_ready, 0);
      tick;
    end
    m_aw_ready = 0;
  endtask

  task automatic w_phase(input bit stalls);
    for (int i = 0; i <= int'(w_len); i++) begin
      logic [63:0] d;
      logic [7:0] st;
      logic [2:0] ln;
      d = {$urandom, $urandom};
      st = strb_q.size() > 0 ? strb_q.pop_front() : 8'($urandom);
      ln = lane_of(w_addr, i, w_size);
      s_w_valid = 1; s_w_data = d; s_w_strb = st; s_w_last = (i == int'(w_len));
      s_b_ready = 1;
      if (stalls && $urandom_range(0, 1) == 1) begin
        m_w_ready = 0;
        #1;
        chk("s_w_ready_stall", s_w_ready, 0);
        chk("m_w_valid_stall", m_w_valid, 1);
        tick;
      end
      m_w_ready = 1;
      #1;
      chk("m_w_valid", m_w_valid, 1);
      chk("s_w_ready", s_w_ready, 1);
      chk("m_w_data", m_w_data, {8{d}});
      chk("m_w_strb", m_w_strb, {56'b0, st} << (8 * ln));
      chk("m_w_last", m_w_last, s_w_last);
      chk("m_b_ready_data", m_b_ready, 0);
      chk("s_aw_ready_data", s_aw_ready, 0);
      tick;
    end
    s_w_valid = 0; s_w_last = 0; m_w_ready = 0; s_b_ready = 0;
  endtask

  task automatic b_phase;
    logic [ID_W-1:0] bid;
    logic [1:0] br;
    bid = ID_W'($urandom);
    br = 2'($urandom);
    m_b_valid = 1; m_b_id = bid; m_b_resp = br; s_b_ready = 0;
    #1;
    chk("s_b_valid_wait", s_b_valid, 1);
    chk("m_b_ready_wait", m_b_ready, 0);
    tick;
    s_b_ready = 1;
    #1;
    chk("s_b_valid", s_b_valid, 1);
    chk("s_b_id", s_b_id, bid);
    chk("s_b_resp", s_b_resp, br);
    chk("m_b_ready", m_b_ready, 1);
    tick;
    #1;
    chk("s_b_valid_after", s_b_valid, 0);
    chk("m_b_ready_after", m_b_ready, 0);
    chk("s_aw_ready_after_b", s_aw_ready, 1);
    m_b_valid = 0; s_b_ready = 0;
  endtask

  task automatic ar_phase(input int stall);
    for (int c = 0; c <= stall; c++) begin
      m_ar_ready = (c == stall);
      s_r_ready = 1;
      #1;
      chk("m_ar_valid", m_ar_valid, 1);
      chk("m_ar_addr", m_ar_addr, {32'b0, r_addr});
      chk("m_ar_len", m_ar_len, r_len);
      chk("m_ar_size", m_ar_size, eff(r_size));
      chk("m_ar_id", m_ar_id, r_id);
      chk("m_r_ready_addr", m_r_ready, 0);
      chk("s_ar_ready_busy", s_ar_ready, 0);
      tick;
    end
    m_ar_ready = 0; s_r_ready = 0;
  endtask

  // nb < 0 runs the whole burst; otherwise stops after nb beats leaving the bus mid-burst
  task automatic r_phase(input bit stalls, input int nb);
    int n;
    n = nb < 0 ? int'(r_len) + 1 : nb;
    for (int i = 0; i < n; i++) begin
      logic [511:0] md;
      logic [2:0] ln;
      logic [ID_W-1:0] rid;
      logic [1:0] rr;
      for (int k = 0; k < 16; k++) md[32*k +: 32] = $urandom;
      ln = lane_of(r_addr, i, r_size);
      rid = ID_W'($urandom);
      rr = 2'($urandom);
      m_r_valid = 1; m_r_data = md; m_r_id = rid; m_r_resp = rr; m_r_last = (i == int'(r_len));
      if (stalls) begin
        s_r_ready = 0;
        for (int h = 0; h < 2; h++) begin
          #1;
          chk("s_r_valid_hold", s_r_valid, 1);
          chk("s_r_data_hold", s_r_data, md[64*ln +: 64]);
          chk("m_r_ready_hold", m_r_ready, 0);
          tick;
        end
      end
      s_r_ready = 1;
      #1;
      chk("s_r_valid", s_r_valid, 1);
      chk("s_r_data", s_r_data, md[64*ln +: 64]);
      chk("s_r_last", s_r_last, m_r_last);
      chk("s_r_id", s_r_id, rid);
      chk("s_r_resp", s_r_resp, rr);
      chk("m_r_ready", m_r_ready, 1);
      tick;
    end
    m_r_last = 0;
    if (nb < 0) begin
      #1;
      chk("s_r_valid_done", s_r_valid, 0);
      chk("m_r_ready_done", m_r_ready, 0);
      chk("s_ar_ready_done", s_ar_ready, 1);
      m_r_valid = 0; s_r_ready = 0;
    end
  endtask

  initial begin
    {s_aw_valid, s_aw_addr, s_aw_len, s_aw_size, s_aw_id} = '0;
    {s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready} = '0;
    {s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_id, s_r_ready} = '0;
    {m_aw_ready, m_w_ready, m_b_valid, m_b_resp, m_b_id, m_ar_ready} = '0;
    {m_r_valid, m_r_data, m_r_resp, m_r_last, m_r_id} = '0;
    reset = 1;
    tick;
    tick;
    reset = 0;
    s_w_valid = 1; m_w_ready = 1; m_b_valid = 1; s_b_ready = 1; m_r_valid = 1; s_r_ready = 1;
    #1;
    chk("rst_m_aw_valid", m_aw_valid, 0);
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_m_w_valid", m_w_valid, 0);
    chk("rst_s_w_ready", s_w_ready, 0);
    chk("rst_s_b_valid", s_b_valid, 0);
    chk("rst_m_b_ready", m_b_ready, 0);
    chk("rst_s_r_valid", s_r_valid, 0);
    chk("rst_m_r_ready", m_r_ready, 0);
    chk("rst_s_aw_ready", s_aw_ready, 1);
    chk("rst_s_ar_ready", s_ar_ready, 1);
    chk("rst_m_aw_addr", m_aw_addr, 0);
    s_w_valid = 0; m_w_ready = 0; m_b_valid = 0; s_b_ready = 0; m_r_valid = 0; s_r_ready = 0;
    tick;

    // 4-beat write starting in lane 5, wrapping to lane 0
    strb_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    issue_aw(32'h28, 8'd3, 3'd3);
    aw_phase(0);
    w_phase(0);
    b_phase();

    // single-beat read from the top lane
    issue_ar(32'h1038, 8'd0, 3'd3);
    ar_phase(0);
    r_phase(0, -1);

    // 4-byte beats: second beat moves into lane 1
    strb_q = '{8'hF0, 8'h0F};
    issue_aw(32'h4, 8'd1, 3'd2);
    aw_phase(0);
    w_phase(0);
    b_phase();

    // slow AW acceptance with a second AW waiting behind the first
    issue_aw(32'h100, 8'd2, 3'd3);
    s_aw_valid = 1; s_aw_addr = 32'h2000; s_aw_len = 8'd1; s_aw_size = 3'd3; s_aw_id = 16'h00A5;
    aw_phase(5);
    w_phase(1);
    b_phase();
    set_aw(32'h2000, 8'd1, 3'd3, 16'h00A5);
    tick;
    s_aw_valid = 0;
    aw_phase(1);
    w_phase(0);
    b_phase();

    // AW and AR accepted on the same edge, R back-pressured
    set_aw(32'h340, 8'd2, 3'd3, ID_W'($urandom));
    set_ar(32'h3C8, 8'd3, 3'd3, ID_W'($urandom));
    s_aw_valid = 1; s_ar_valid = 1;
    #1;
    chk("dual_s_aw_ready", s_aw_ready, 1);
    chk("dual_s_ar_ready", s_ar_ready, 1);
    tick;
    s_aw_valid = 0; s_ar_valid = 0;
    #1;
    chk("dual_m_aw_valid", m_aw_valid, 1);
    chk("dual_m_ar_valid", m_ar_valid, 1);
    ar_phase(2);
    r_phase(1, -1);
    aw_phase(0);
    w_phase(0);
    b_phase();

    // reset while beat 2 of an 8-beat read is on the bus
    issue_ar(32'h5000, 8'd7, 3'd3);
    ar_phase(0);
    r_phase(0, 2);
    s_r_ready = 1;
    reset = 1;
    tick;
    reset = 0;
    #1;
    chk("mid_rst_m_r_ready", m_r_ready, 0);
    chk("mid_rst_s_r_valid", s_r_valid, 0);
    chk("mid_rst_s_ar_ready", s_ar_ready, 1);
    chk("mid_rst_s_aw_ready", s_aw_ready, 1);
    m_r_valid = 0; s_r_ready = 0;
    tick;
    issue_ar(32'h6010, 8'd2, 3'd3);
    ar_phase(0);
    r_phase(0, -1);

    // randomized transactions including narrow and oversized beat sizes
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      logic [7:0] l;
      logic [2:0] s;
      a = $urandom;
      l = 8'($urandom_range(0, 5));
      s = 3'($urandom_range(0, 7));
      if (t == 11) a = 32'hFFFF_FFF0;
      if (t % 2 == 0) begin
        issue_aw(a, l, s);
        aw_phase($urandom_range(0, 3));
        w_phase(1);
        b_phase();
      end else begin
        issue_ar(a, l, s);
        ar_phase($urandom_range(0, 3));
        r_phase($urandom_range(0, 1) == 1, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
